fp_rept: RTL and testbench
==========================

# fp_rept

- Representative (sticky-reduction) stage at the front of the FPU rounder.
- Takes the 128-bit normalized significand `fn` and collapses it to a 55-bit representative `f1`.
  - Keeps the bits needed for rounding: p+1 leading bits plus one sticky bit, for double (p=53) or single (p=24) precision.
- Output is registered, so the stage fits the pipelined rounder datapath.

## Interface
- Parameters: none.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: `fn` and `db` are valid this cycle.
- `fn` input 128: normalized significand, bit 127 = leading (integer) bit.
- `db` input 1: 1 = double precision, 0 = single precision.
- `out_valid` output 1: `f1` holds a new result.
- `f1` output 55: registered representative.

## Operation
- Double (`db`=1):
  - f1[54:1] = fn[127:74].
  - f1[0] = OR of fn[73:0].
- Single (`db`=0):
  - f1[54:30] = fn[127:103].
  - f1[29] = OR of fn[102:0].
  - f1[28:0] = 0.
- The sticky bit is 1 if and only if any discarded bit is 1. No other transformation is applied: no shifting, no rounding, no exponent handling.
- Input is not checked for normalization; any `fn` pattern is processed bitwise as above.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on `f1`/`out_valid` after edge N.
- `out_valid` at edge N+1 equals `in_valid` at edge N.
- `f1` loads only when `in_valid`=1 and otherwise holds its previous value.
- No backpressure: a new input is accepted every cycle.
- `db` is sampled together with `fn`; a `db` change applies only to the transaction it accompanies.
- Reset:
  - `rst_n` low forces `f1`=0 and `out_valid`=0 immediately, regardless of clock.
  - Reset asserted mid-operation discards the in-flight result.
  - The first valid output after release appears one cycle after the first `in_valid`.

## Configuration
- `REPT_ZERO_FLAG_EN`:
  - Defined: adds output `fn_zero` (1 bit), registered with the same latency and enable as `f1`. It is 1 when all 128 bits of `fn` are 0. Reset value is 0.
  - Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package `fpu_pkg` holds:
  - `FN_W`=128 and `F1_W`=55.
  - Precision cut constants `DBL_KEEP`=54 and `SGL_KEEP`=25.
  - Sticky boundaries `DBL_STICKY_HI`=73 and `SGL_STICKY_HI`=102.
- One sub-module, `rept_sticky`: combinational OR-reduction of `fn` returning both sticky bits (double and single). It uses a balanced tree so it does not form the critical path.
- Top level: precision mux, output register, valid pipeline, optional zero flag.

## Test plan
- `db`=1, `fn`=128'hA1B2C3D4E5F60789ABCDEF0123456789 -> `f1`=55'h50D961EA72FB03 one cycle later, `out_valid`=1.
- `db`=0, `fn`=128'h1234567890ABCDEFFEDCBA0987654321 -> `f1`=55'h091A2B20000000.
- `db`=1, `fn`=128'h87654321ABCDEF0123456789ABCDE012 -> `f1`=55'h43B2A190D5E6F7.
- `db`=0, `fn`=128'hAABBCCDD00112233445566778899AABB -> `f1`=55'h555DE660000000.
- Sticky boundaries:
  - `db`=1, `fn`=128'h1 -> `f1`=55'h1.
  - `db`=0, `fn`=128'h1 -> `f1`=55'h20000000.
  - `db`=1, `fn`=1<<127 -> `f1`=55'h40000000000000 (sticky 0).
- Control:
  - `in_valid`=0 holds `f1`.
  - Asserting `rst_n`=0 mid-stream clears `f1`/`out_valid` asynchronously.
  - Back-to-back valid inputs yield back-to-back outputs.
  - With `REPT_ZERO_FLAG_EN` defined, `fn`=0 gives `fn_zero`=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
//   Constants and types shared by the FPU rounder front-end.
//   - FN_W / F1_W          : normalized significand and representative widths
//   - DBL_KEEP / SGL_KEEP  : leading bits kept (p+1) for double / single
//   - *_STICKY_HI          : top index of the bits folded into the sticky bit
//   - prec_e               : precision select, encoded to match the db input
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int unsigned FN_W          = 128;
  localparam int unsigned F1_W          = 55;

  localparam int unsigned DBL_KEEP      = 54;
  localparam int unsigned SGL_KEEP      = 25;

  localparam int unsigned DBL_STICKY_HI = 73;
  localparam int unsigned SGL_STICKY_HI = 102;

  typedef enum logic {
    PREC_SGL = 1'b0,
    PREC_DBL = 1'b1
  } prec_e;

endpackage : fpu_pkg

// File: rtl/rept_sticky.sv
// -----------------------------------------------------------------------------
// rept_sticky
//   Combinational OR-reduction of the normalized significand producing the
//   sticky bit for both precisions.
//   Ports:
//     fn       in  [FN_W-1:0]  normalized significand
//     stk_dbl  out             OR of fn[DBL_STICKY_HI:0]
//     stk_sgl  out             OR of fn[SGL_STICKY_HI:0]
// -----------------------------------------------------------------------------
module rept_sticky
  import fpu_pkg::*;
(
  input  logic [FN_W-1:0] fn,
  output logic            stk_dbl,
  output logic            stk_sgl
);

  logic lo_or;
  logic mid_or;

  // The single-precision sticky range is a superset of the double range, so
  // it is split into two disjoint segments reduced in parallel; each
  // reduction maps to a balanced OR tree and the single sticky costs only
  // one extra OR level on top of the shared lower segment.
  always_comb begin
    lo_or   = |fn[DBL_STICKY_HI:0];
    mid_or  = |fn[SGL_STICKY_HI:DBL_STICKY_HI+1];
    stk_dbl = lo_or;
    stk_sgl = lo_or | mid_or;
  end

endmodule : rept_sticky

// File: rtl/fp_rept.sv
// -----------------------------------------------------------------------------
// fp_rept
//   Representative (sticky-reduction) stage at the front of the FPU rounder.
//   Collapses the 128-bit normalized significand to a 55-bit representative:
//   p+1 leading bits plus a sticky bit, for double or single precision.
//   One-cycle registered latency, no backpressure.
//   Ports:
//     clk        in            rising-edge clock
//     rst_n      in            asynchronous active-low reset
//     in_valid   in            fn/db valid this cycle
//     fn         in  [127:0]   normalized significand, bit 127 leading
//     db         in            1 = double, 0 = single
//     out_valid  out           f1 holds a new result
//     f1         out [54:0]    registered representative
//     fn_zero    out           (REPT_ZERO_FLAG_EN only) fn was all zeros
//   Configuration macro: REPT_ZERO_FLAG_EN adds the registered fn_zero flag.
// -----------------------------------------------------------------------------
module fp_rept
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [FN_W-1:0] fn,
  input  logic            db,
  output logic            out_valid,
  output logic [F1_W-1:0] f1
`ifdef REPT_ZERO_FLAG_EN
  ,
  output logic            fn_zero
`endif
);

  logic            stk_dbl;
  logic            stk_sgl;
  prec_e           prec;
  logic [F1_W-1:0] rep;

  logic [F1_W-1:0] f1_d,        f1_q;
  logic            out_valid_d, out_valid_q;

  rept_sticky u_sticky (
    .fn      (fn),
    .stk_dbl (stk_dbl),
    .stk_sgl (stk_sgl)
  );

  // Precision mux: keep the leading bits, append the sticky, zero-fill below.
  always_comb begin
    prec = prec_e'(db);
    rep  = '0;
    case (prec)
      PREC_DBL: rep = {fn[FN_W-1 -: DBL_KEEP], stk_dbl};
      PREC_SGL: rep = {fn[FN_W-1 -: SGL_KEEP], stk_sgl,
                       {(F1_W-SGL_KEEP-1){1'b0}}};
      default:  rep = '0;
    endcase
  end

  always_comb begin
    out_valid_d = in_valid;
    f1_d        = in_valid ? rep : f1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      f1_q        <= f1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign f1        = f1_q;
  assign out_valid = out_valid_q;

`ifdef REPT_ZERO_FLAG_EN
  logic fn_zero_d, fn_zero_q;

  // The single sticky already covers fn[102:0]; only the kept bits remain.
  always_comb begin
    fn_zero_d = fn_zero_q;
    if (in_valid) begin
      fn_zero_d = ~(stk_sgl | (|fn[FN_W-1:SGL_STICKY_HI+1]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn_zero_q <= 1'b0;
    end else begin
      fn_zero_q <= fn_zero_d;
    end
  end

  assign fn_zero = fn_zero_q;
`endif

endmodule : fp_rept

// File: tb/tb_fp_rept.sv
module tb_fp_rept;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] fn;
  logic         db;
  logic         out_valid;
  logic [54:0]  f1;
`ifdef REPT_ZERO_FLAG_EN
  logic         fn_zero;
`endif

  typedef struct {
    logic [54:0] f1;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fp_rept dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .fn        (fn),
    .db        (db),
    .out_valid (out_valid),
    .f1        (f1)
`ifdef REPT_ZERO_FLAG_EN
    ,
    .fn_zero   (fn_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model built from shifts and masks.
  function automatic logic [54:0] ref_f1(input logic d, input logic [127:0] v);
    logic [127:0] mask;
    logic [127:0] hi;
    logic         s;
    if (d) begin
      mask = (128'd1 << 74) - 128'd1;
      s    = ((v & mask) != 128'd0);
      hi   = (v >> 74) << 1;
      return hi[54:0] | {54'd0, s};
    end else begin
      mask = (128'd1 << 103) - 128'd1;
      s    = ((v & mask) != 128'd0);
      hi   = (v >> 103) << 30;
      return hi[54:0] | (55'd1 << 29) * s;
    end
  endfunction

  task automatic send_exp(input logic d, input logic [127:0] v,
                          input logic [54:0] e);
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    db       = d;
    fn       = v;
    x.f1     = e;
    x.zero   = (v == 128'd0);
    sb.push_back(x);
  endtask

  task automatic send(input logic d, input logic [127:0] v);
    send_exp(d, v, ref_f1(d, v));
  endtask

  // Scoreboard consumer: every valid output pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("f1", {9'd0, f1}, {9'd0, e.f1});
`ifdef REPT_ZERO_FLAG_EN
        check("fn_zero", {63'd0, fn_zero}, {63'd0, e.zero});
`endif
      end
    end
  end

  initial begin
    logic [127:0] v;
    logic [54:0]  held;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    db       = 1'b0;
    fn       = '0;
    #12;
    check("reset_f1", {9'd0, f1}, 64'd0);
    check("reset_ov", {63'd0, out_valid}, 64'd0);
`ifdef REPT_ZERO_FLAG_EN
    check("reset_zero", {63'd0, fn_zero}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with independently derived results.
    send_exp(1'b1, 128'hA1B2C3D4E5F60789ABCDEF0123456789, 55'h50D961EA72FB03);
    send_exp(1'b0, 128'h1234567890ABCDEFFEDCBA0987654321, 55'h091A2B20000000);
    send_exp(1'b1, 128'h87654321ABCDEF0123456789ABCDE012, 55'h43B2A190D5E6F7);
    send_exp(1'b0, 128'hAABBCCDD00112233445566778899AABB, 55'h555DE660000000);
    send_exp(1'b1, 128'h1, 55'h1);
    send_exp(1'b0, 128'h1, 55'h20000000);
    send_exp(1'b1, 128'h1 << 127, 55'h40000000000000);
    send_exp(1'b0, 128'h1 << 127, 55'h40000000000000);
    // Edges of the sticky ranges.
    send_exp(1'b1, 128'h1 << 73, 55'h1);
    send_exp(1'b1, 128'h1 << 74, 55'h2);
    send_exp(1'b0, 128'h1 << 102, 55'h20000000);
    send_exp(1'b0, 128'h1 << 103, 55'h40000000);
    send_exp(1'b1, 128'h0, 55'h0);
    send_exp(1'b0, 128'h0, 55'h0);
    send_exp(1'b1, ~128'h0, 55'h7FFFFFFFFFFFFF);
    send_exp(1'b0, ~128'h0, 55'h7FFFFFE0000000);

    // Hold: in_valid low keeps f1 while inputs change.
    v = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, v);
    held = ref_f1(1'b1, v);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      db       = i[0];
      fn       = {$urandom, $urandom, $urandom, $urandom};
      if (i > 0) begin
        check("hold_f1", {9'd0, f1}, {9'd0, held});
        check("hold_ov", {63'd0, out_valid}, 64'd0);
      end
    end

    // Back-to-back random stream with mixed precision.
    for (int i = 0; i < 24; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      if (i % 5 == 0) v[73:0] = '0;
      if (i % 7 == 0) v[102:0] = '0;
      send(1'($urandom_range(0, 1)), v);
    end

    // Reset asserted with a result on the outputs and another in flight.
    send(1'b1, 128'hFEDCBA98765432100123456789ABCDEF);
    @(posedge clk);
    #2;
    check("pre_rst_ov", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_f1", {9'd0, f1}, 64'd0);
    check("async_rst_ov", {63'd0, out_valid}, 64'd0);
    sb.delete();
    @(negedge clk);
    in_valid = 1'b1;
    db       = 1'b0;
    fn       = 128'hFFFF0000FFFF0000FFFF0000FFFF0000;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ov", {63'd0, out_valid}, 64'd0);
    check("post_rst_f1", {9'd0, f1}, 64'd0);

    // First transaction after release.
    send_exp(1'b0, 128'h1234567890ABCDEFFEDCBA0987654321, 55'h091A2B20000000);
    send(1'b1, 128'h0);
    @(negedge clk);
    in_valid = 1'b0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_pending", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fp_rept
